// File: rtl/divider_sched_pkg.sv
// Shared definitions for the divider scheduler.
// Holds the divider tag layout (requester ID in the upper bits, per-requester
// sequence number in the lower bits), the FSM state type and the width of
// the per-requester outstanding-operation counters.
package divider_sched_pkg;

    localparam int TAG_W    = 6;
    localparam int REQ_ID_W = 2;
    localparam int SEQ_W    = 4;

    // Tag field positions: tag = {requester_id, sequence_number}
    localparam int TAG_SEQ_LSB = 0;
    localparam int TAG_SEQ_MSB = TAG_SEQ_LSB + SEQ_W - 1;
    localparam int TAG_ID_LSB  = TAG_SEQ_MSB + 1;
    localparam int TAG_ID_MSB  = TAG_ID_LSB + REQ_ID_W - 1;

    // Outstanding counters hold 0..16 and never wrap.
    localparam int CNT_W = 5;

    typedef enum logic {
        FLUSH = 1'b0,
        RUN   = 1'b1
    } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter.
// Grants the first eligible requester at or after the pointer, wrapping
// around. The pointer moves to one past the granted requester whenever a
// grant is given and holds otherwise. A grant is only ever given to an
// eligible (hence valid) requester, so every grant is an issue.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset (pointer -> 0)
//   eligible     per-requester eligibility vector
//   grant        one-hot grant vector (all zero when nothing is eligible)
//   grant_id     index of the granted requester
//   grant_valid  a grant is being given this cycle
module rr_arbiter
    import divider_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_REQ-1:0]  eligible,
    output logic [NUM_REQ-1:0]  grant,
    output logic [REQ_ID_W-1:0] grant_id,
    output logic                grant_valid
);

    logic [REQ_ID_W-1:0] ptr;

    // Index k positions after p, wrapping at NUM_REQ (p < NUM_REQ, k < NUM_REQ).
    function automatic int rr_idx(input int p, input int k);
        int s;
        s = p + k;
        return (s >= NUM_REQ) ? s - NUM_REQ : s;
    endfunction

    // NOTE: every output gets a default before the loop so no path through
    // the block leaves a value unassigned, which would infer a latch.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!grant_valid && (j == rr_idx(int'(ptr), k)) && eligible[j]) begin
                    grant[j]    = 1'b1;
                    grant_id    = REQ_ID_W'(j);
                    grant_valid = 1'b1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (grant_valid) begin
            if (int'(grant_id) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_id + 1'b1;
            end
        end
    end

endmodule

// File: rtl/divider_scheduler.sv
// Divider scheduler: shares one fixed-latency pipelined divider among
// NUM_REQ requesters.
// A round-robin arbiter issues at most one operation per cycle. Each issue is
// tagged {requester_id, issue_seq}; the returned tag routes the result back
// to its requester. After reset a FLUSH window discards whatever the
// (unresettable) divider still holds. Per-requester outstanding counters
// bound in-flight work to MAX_OUT, and returns are checked for in-order
// sequence numbers; any inconsistent return sets the sticky err_seq.
//
// Ports:
//   clock, reset_n                      clock, asynchronous active-low reset
//   req_valid / req_ready               per-requester handshake (ready is
//                                       combinational, one-hot)
//   req_dividend / req_divisor          packed operands, requester i at slice i
//   div_input_valid/_tag, div_dividend, div_divisor   issue to divider (registered)
//   div_output_valid/_tag, div_quotient, div_remainder results from divider
//   rsp_valid                           one-hot result strobe (registered)
//   rsp_quotient / rsp_remainder        shared result bus (registered)
//   err_seq                             sticky tag/sequence error
module divider_scheduler
    import divider_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8,
    parameter int DIV_LATENCY    = 19,
    parameter int MAX_OUT        = 8
) (
    input  logic                              clock,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0] req_dividend,
    input  logic [NUM_REQ*DIVISOR_WIDTH-1:0]  req_divisor,
    output logic                              div_input_valid,
    output logic [TAG_W-1:0]                  div_input_tag,
    output logic [DIVIDEND_WIDTH-1:0]         div_dividend,
    output logic [DIVISOR_WIDTH-1:0]          div_divisor,
    input  logic                              div_output_valid,
    input  logic [TAG_W-1:0]                  div_output_tag,
    input  logic [DIVIDEND_WIDTH-1:0]         div_quotient,
    input  logic [DIVIDEND_WIDTH-1:0]         div_remainder,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [DIVIDEND_WIDTH-1:0]         rsp_quotient,
    output logic [DIVIDEND_WIDTH-1:0]         rsp_remainder,
    output logic                              err_seq
);

    localparam int FLUSH_W = $clog2(DIV_LATENCY + 1);

    sched_state_e        state, state_next;
    logic [FLUSH_W-1:0]  flush_cnt;
    logic                run;

    logic [CNT_W-1:0]    outstanding [NUM_REQ];
    logic [SEQ_W-1:0]    issue_seq   [NUM_REQ];
    logic [SEQ_W-1:0]    expect_seq  [NUM_REQ];

    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic [REQ_ID_W-1:0] grant_id;
    logic                grant_valid;

    logic [DIVIDEND_WIDTH-1:0] sel_dividend;
    logic [DIVISOR_WIDTH-1:0]  sel_divisor;
    logic [SEQ_W-1:0]          sel_seq;

    logic [REQ_ID_W-1:0] ret_id;
    logic [SEQ_W-1:0]    ret_seq;
    logic [NUM_REQ-1:0]  ret_hit;
    logic                ret_err;

    // ------------------------------------------------------------------
    // FSM: FLUSH covers the divider latency after reset so stale results
    // left in the unresettable pipeline never reach a requester.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FLUSH;
            flush_cnt <= FLUSH_W'(DIV_LATENCY);
        end else begin
            state <= state_next;
            if (state == FLUSH && flush_cnt != '0) begin
                flush_cnt <= flush_cnt - 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        if (state == FLUSH && flush_cnt == '0) begin
            state_next = RUN;
        end
    end

    always_comb begin
        run = (state == RUN);
    end

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = run && req_valid[i] && (outstanding[i] < CNT_W'(MAX_OUT));
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .clock       (clock),
        .reset_n     (reset_n),
        .eligible    (eligible),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    always_comb begin
        sel_dividend = '0;
        sel_divisor  = '0;
        sel_seq      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_dividend = req_dividend[i*DIVIDEND_WIDTH +: DIVIDEND_WIDTH];
                sel_divisor  = req_divisor[i*DIVISOR_WIDTH +: DIVISOR_WIDTH];
                sel_seq      = issue_seq[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Return decode: a return is accepted only if its requester exists,
    // its sequence number is the one expected and something is in flight.
    // An out-of-range requester ID matches no index and falls into error.
    // ------------------------------------------------------------------
    assign ret_id  = div_output_tag[TAG_ID_MSB:TAG_ID_LSB];
    assign ret_seq = div_output_tag[TAG_SEQ_MSB:TAG_SEQ_LSB];

    always_comb begin
        ret_hit = '0;
        ret_err = 1'b0;
        if (run && div_output_valid) begin
            ret_err = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if ((int'(ret_id) == i) && (ret_seq == expect_seq[i]) &&
                    (outstanding[i] != '0)) begin
                    ret_hit[i] = 1'b1;
                    ret_err    = 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_input_valid <= 1'b0;
            div_input_tag   <= '0;
            div_dividend    <= '0;
            div_divisor     <= '0;
        end else begin
            div_input_valid <= grant_valid;
            if (grant_valid) begin
                div_input_tag <= {grant_id, sel_seq};
                div_dividend  <= sel_dividend;
                div_divisor   <= sel_divisor;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-requester counters. An issue and an accepted return for the same
    // requester in one cycle leave outstanding unchanged while both
    // sequence numbers advance.
    // ------------------------------------------------------------------
    // NOTE: these counter arrays are reset explicitly; they are small flop
    // arrays, not RAM, and stale counts would corrupt credit and ordering.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                outstanding[i] <= '0;
                issue_seq[i]   <= '0;
                expect_seq[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                case ({grant[i], ret_hit[i]})
                    2'b10:   outstanding[i] <= outstanding[i] + 1'b1;
                    2'b01:   outstanding[i] <= outstanding[i] - 1'b1;
                    default: outstanding[i] <= outstanding[i];
                endcase
                if (grant[i]) begin
                    issue_seq[i] <= issue_seq[i] + 1'b1;
                end
                if (ret_hit[i]) begin
                    expect_seq[i] <= expect_seq[i] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid     <= '0;
            rsp_quotient  <= '0;
            rsp_remainder <= '0;
            err_seq       <= 1'b0;
        end else begin
            rsp_valid <= ret_hit;
            if (ret_hit != '0) begin
                rsp_quotient  <= div_quotient;
                rsp_remainder <= div_remainder;
            end
            if (ret_err) begin
                err_seq <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_divider_scheduler.sv
// Testbench for divider_scheduler.
// Contains a behavioural model of the shared divider (fixed latency, no
// reset, power-on garbage in the pipeline). Stimulus pushes hand-computed
// expected results into a scoreboard queue when a request is accepted; a
// monitor pops and compares whenever rsp_valid is seen, including the
// arrival cycle.
module tb_divider_scheduler;

    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int SW      = 8;
    localparam int LAT     = 19;
    localparam int MAX_OUT = 2;
    localparam int E2E     = LAT + 2;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DW-1:0]     req_dividend;
    logic [NUM_REQ*SW-1:0]     req_divisor;
    logic                      div_input_valid;
    logic [5:0]                div_input_tag;
    logic [DW-1:0]             div_dividend;
    logic [SW-1:0]             div_divisor;
    logic                      div_output_valid;
    logic [5:0]                div_output_tag;
    logic [DW-1:0]             div_quotient;
    logic [DW-1:0]             div_remainder;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DW-1:0]             rsp_quotient;
    logic [DW-1:0]             rsp_remainder;
    logic                      err_seq;

    always #5 clock = ~clock;

    divider_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .DIVIDEND_WIDTH (DW),
        .DIVISOR_WIDTH  (SW),
        .DIV_LATENCY    (LAT),
        .MAX_OUT        (MAX_OUT)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_dividend     (req_dividend),
        .req_divisor      (req_divisor),
        .div_input_valid  (div_input_valid),
        .div_input_tag    (div_input_tag),
        .div_dividend     (div_dividend),
        .div_divisor      (div_divisor),
        .div_output_valid (div_output_valid),
        .div_output_tag   (div_output_tag),
        .div_quotient     (div_quotient),
        .div_remainder    (div_remainder),
        .rsp_valid        (rsp_valid),
        .rsp_quotient     (rsp_quotient),
        .rsp_remainder    (rsp_remainder),
        .err_seq          (err_seq)
    );

    // ------------------------------------------------------------------
    // Divider model: LAT-stage pipeline, no reset, filled with valid
    // garbage on the first clock to mimic power-up contents.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic          valid;
        logic [5:0]    tag;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
    } div_stage_t;

    div_stage_t pipe [LAT];
    logic       pipe_filled = 1'b0;
    logic       inj_valid   = 1'b0;
    logic [5:0] inj_tag     = 6'h00;

    function automatic div_stage_t div_model(input logic v, input logic [5:0] tag,
                                             input logic [DW-1:0] a, input logic [SW-1:0] d);
        div_stage_t s;
        int sa, ud;
        sa      = int'($signed(a));
        ud      = int'(d);
        s.valid = v;
        s.tag   = tag;
        if (ud == 0) begin
            s.q = 16'hFFFF;
            s.r = a;
        end else begin
            s.q = 16'(sa / ud);
            s.r = 16'(sa % ud);
        end
        return s;
    endfunction

    always @(posedge clock) begin
        if (!pipe_filled) begin
            for (int k = 0; k < LAT; k++) begin
                pipe[k] <= '{valid: 1'b1, tag: 6'(k), q: 16'hDEAD, r: 16'hBEEF};
            end
            pipe_filled <= 1'b1;
        end else begin
            pipe[0] <= div_model(div_input_valid, div_input_tag, div_dividend, div_divisor);
            for (int k = 1; k < LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    assign div_output_valid = inj_valid | pipe[LAT-1].valid;
    assign div_output_tag   = inj_valid ? inj_tag : pipe[LAT-1].tag;
    assign div_quotient     = pipe[LAT-1].q;
    assign div_remainder    = pipe[LAT-1].r;

    // ------------------------------------------------------------------
    // Scoreboard and checking
    // ------------------------------------------------------------------
    typedef struct {
        int            id;
        logic [DW-1:0] q;
        logic [DW-1:0] r;
        int            cyc;
    } exp_t;

    exp_t          sb [$];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    logic [DW-1:0] exp_q  [NUM_REQ];
    logic [DW-1:0] exp_r  [NUM_REQ];
    logic [3:0]    tb_seq [NUM_REQ];
    logic          pend;
    logic [5:0]    pend_tag;
    logic [DW-1:0] pend_a;
    logic [SW-1:0] pend_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: issue check one cycle after each accept, scoreboard push on
    // accept, scoreboard pop on every result strobe.
    always @(negedge clock) begin
        if (!reset_n) begin
            sb.delete();
            pend   <= 1'b0;
            tb_seq <= '{default: 4'h0};
        end else begin
            if (pend) begin
                check("issue_valid", 32'(div_input_valid), 32'd1);
                check("issue_tag", 32'(div_input_tag), 32'(pend_tag));
                check("issue_dividend", 32'(div_dividend), 32'(pend_a));
                check("issue_divisor", 32'(div_divisor), 32'(pend_d));
            end else begin
                check("no_spurious_issue", 32'(div_input_valid), 32'd0);
            end
            pend <= 1'b0;
            if ((req_valid & req_ready) != '0) begin
                check("grant_onehot", 32'($countones(req_valid & req_ready)), 32'd1);
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        sb.push_back('{id: i, q: exp_q[i], r: exp_r[i], cyc: cyc + E2E});
                        pend     <= 1'b1;
                        pend_tag <= {2'(i), tb_seq[i]};
                        pend_a   <= req_dividend[i*DW +: DW];
                        pend_d   <= req_divisor[i*SW +: SW];
                        tb_seq[i] <= tb_seq[i] + 4'h1;
                    end
                end
            end
            if (rsp_valid != '0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_rsp: rsp_valid=%b with no result pending (cycle %0d)",
                             rsp_valid, cyc);
                end else begin
                    check("rsp_valid", 32'(rsp_valid), 32'(1 << sb[0].id));
                    check("rsp_quotient", 32'(rsp_quotient), 32'(sb[0].q));
                    check("rsp_remainder", 32'(rsp_remainder), 32'(sb[0].r));
                    check("rsp_cycle", 32'(cyc), 32'(sb[0].cyc));
                    void'(sb.pop_front());
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [SW-1:0] d,
                           input logic [DW-1:0] q, input logic [DW-1:0] r);
        req_dividend[i*DW +: DW] = a;
        req_divisor[i*SW +: SW]  = d;
        exp_q[i] = q;
        exp_r[i] = r;
    endtask

    task automatic send(input int i, input logic [DW-1:0] a, input logic [SW-1:0] d,
                        input logic [DW-1:0] q, input logic [DW-1:0] r);
        bit got = 1'b0;
        @(posedge clock);
        #1;
        set_req(i, a, d, q, r);
        req_valid[i] = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clock);
            got = req_ready[i];
        end
        @(posedge clock);
        #1;
        req_valid[i] = 1'b0;
        check("send_accept", 32'(got), 32'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clock);
            n++;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge clock);
    endtask

    task automatic load_rr_vectors();
        set_req(0, 16'h0032, 8'd5,   16'h000A, 16'h0000);  //     50/5   =     10 r 0
        set_req(1, 16'hFFF9, 8'd2,   16'hFFFD, 16'hFFFF);  //     -7/2   =     -3 r -1
        set_req(2, 16'h7FFF, 8'd255, 16'h0080, 16'h007F);  //  32767/255 =    128 r 127
        set_req(3, 16'h8000, 8'd1,   16'h8000, 16'h0000);  // -32768/1   = -32768 r 0
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed test sequence
    // ------------------------------------------------------------------
    initial begin
        int n_acc;
        int acc [3];
        bit found;

        reset_n      = 1'b0;
        req_valid    = '0;
        req_dividend = '0;
        req_divisor  = '0;
        exp_q        = '{default: 16'h0};
        exp_r        = '{default: 16'h0};
        acc          = '{default: 0};

        // Reset values
        @(negedge clock);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_div_valid", 32'(div_input_valid), 32'd0);
        check("rst_div_tag", 32'(div_input_tag), 32'd0);
        check("rst_div_dividend", 32'(div_dividend), 32'd0);
        check("rst_div_divisor", 32'(div_divisor), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_q", 32'(rsp_quotient), 32'd0);
        check("rst_rsp_r", 32'(rsp_remainder), 32'd0);
        check("rst_err", 32'(err_seq), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // FLUSH: all requesters valid, none may be accepted; power-on
        // garbage emerging from the divider must be discarded.
        load_rr_vectors();
        req_valid = '1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clock);
            check("flush_ready", 32'(req_ready), 32'd0);
        end
        found = 1'b0;
        for (int n = 0; n < 10 && !found; n++) begin
            @(negedge clock);
            found = (req_ready != '0);
        end
        check("run_entry", 32'(found), 32'd1);

        // Round-robin fairness: grants 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clock);
            check("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        check("err_after_poweron", 32'(err_seq), 32'd0);
        drain();

        // Single op, requester 0: 100/7 = 14 r 2
        send(0, 16'd100, 8'd7, 16'd14, 16'd2);
        drain();

        // Negative dividend, requester 2: -100/7 = -14 r -2
        send(2, 16'hFF9C, 8'd7, 16'hFFF2, 16'hFFFE);
        drain();

        // Credit limit (MAX_OUT=2): requester 1 held valid
        @(posedge clock);
        #1;
        set_req(1, 16'd1000, 8'd9, 16'd111, 16'd1);
        req_valid[1] = 1'b1;
        n_acc = 0;
        for (int n = 0; n < 60 && n_acc < 3; n++) begin
            @(negedge clock);
            if (req_ready[1]) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
        end
        @(posedge clock);
        #1;
        req_valid[1] = 1'b0;
        check("credit_accepts", 32'(n_acc), 32'd3);
        check("credit_back2back", 32'(acc[1] - acc[0]), 32'd1);
        check("credit_reopen", 32'(acc[2] - acc[0]), 32'(E2E));
        drain();

        // Reset mid-flight: five ops in flight, then a 2-cycle reset pulse
        @(posedge clock);
        #1;
        set_req(0, 16'd200, 8'd10, 16'd20, 16'd0);
        set_req(2, 16'hFFCE, 8'd8, 16'hFFFA, 16'hFFFE);
        set_req(3, 16'd9, 8'd4, 16'd2, 16'd1);
        req_valid = 4'b1101;
        n_acc = 0;
        for (int n = 0; n < 20 && n_acc < 5; n++) begin
            @(negedge clock);
            n_acc += $countones(req_valid & req_ready);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        check("midflight_issued", 32'(n_acc), 32'd5);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(negedge clock);
        check("midrst_ready", 32'(req_ready), 32'd0);
        check("midrst_div_valid", 32'(div_input_valid), 32'd0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        load_rr_vectors();
        req_valid = '1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clock);
            check("reflush_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clock);
        #1;
        req_valid = '0;
        repeat (5) @(negedge clock);
        check("err_after_reflush", 32'(err_seq), 32'd0);

        // Recovery after reset: requester 3, 7/3 = 2 r 1, tag 0x30
        send(3, 16'd7, 8'd3, 16'd2, 16'd1);
        drain();

        // Tag fault: tag 0x05 while requester 0 expects seq 0 with nothing out
        @(posedge clock);
        #1;
        inj_tag   = 6'h05;
        inj_valid = 1'b1;
        @(posedge clock);
        #1;
        inj_valid = 1'b0;
        @(negedge clock);
        check("fault_err_set", 32'(err_seq), 32'd1);
        check("fault_no_rsp", 32'(rsp_valid), 32'd0);

        // Requester 0 still works normally (counters untouched): -1/1 = -1 r 0
        send(0, 16'hFFFF, 8'd1, 16'hFFFF, 16'h0000);
        drain();
        check("err_sticky", 32'(err_seq), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/divider_scheduler.md
Name: divider_scheduler

Overview:
- Shares one pipelined signed-by-unsigned divider (16-bit dividend, 8-bit divisor, 6-bit tag, fixed latency, no stall, no reset) among NUM_REQ requesters.
- Round-robin arbitration picks at most one issue per cycle.
- Each issue is tagged with requester ID and sequence number; the returned tag routes the result back to its requester.
- Also masks stale pipeline contents after reset, bounds outstanding operations per requester, and checks in-order return.

Parameters:
- NUM_REQ, 4, number of requesters; 1..4.
- DIVIDEND_WIDTH, 16, dividend/quotient/remainder width; must match the divider.
- DIVISOR_WIDTH, 8, divisor width; must match the divider.
- DIV_LATENCY, 19, cycles from div_input_valid to div_output_valid (DIVIDEND_WIDTH+3).
- MAX_OUT, 8, maximum outstanding ops per requester; 1..16.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept
- req_dividend  in  NUM_REQ*DIVIDEND_WIDTH  packed signed dividends; requester i at slice i
- req_divisor  in  NUM_REQ*DIVISOR_WIDTH  packed unsigned divisors
- div_input_valid  out  1  to divider
- div_input_tag  out  6  to divider
- div_dividend  out  DIVIDEND_WIDTH  to divider
- div_divisor  out  DIVISOR_WIDTH  to divider
- div_output_valid  in  1  from divider
- div_output_tag  in  6  from divider
- div_quotient  in  DIVIDEND_WIDTH  from divider
- div_remainder  in  DIVIDEND_WIDTH  from divider
- rsp_valid  out  NUM_REQ  one-hot result strobe; no backpressure
- rsp_quotient  out  DIVIDEND_WIDTH  shared result bus
- rsp_remainder  out  DIVIDEND_WIDTH  shared result bus
- err_seq  out  1  sticky tag/sequence error

Behaviour:
- Reset: all outputs are registered except req_ready.
  - Asynchronous reset clears: div_input_valid, rsp_valid, err_seq, all outstanding counters, issue and expect sequence numbers, and the RR pointer (to 0).
  - Reset forces state FLUSH and loads the flush counter with DIV_LATENCY.
  - Reset clears div_input_tag, div_dividend, div_divisor, rsp_quotient and rsp_remainder to 0.
- FSM: FLUSH -> RUN when the flush counter reaches 0 (decrements once per cycle).
  - In FLUSH: req_ready=0, div_input_valid=0, and every div_output_valid is discarded (the divider has no reset, so its contents are stale).
  - RUN persists until reset.
- Eligibility: eligible[i] = RUN & req_valid[i] & (outstanding[i] < MAX_OUT).
- Grant: the first eligible index at or after the RR pointer, wrapping.
  - req_ready is combinational and one-hot; it is 1 only for the granted requester.
  - req_ready does not depend on req_valid of non-eligible requesters.
- Issue: on req_valid[g] & req_ready[g], the next cycle drives:
  - div_input_valid=1.
  - div_input_tag = {g[1:0], issue_seq[g][3:0]}.
  - div_dividend and div_divisor taken from slice g.
  - Then issue_seq[g]++ (mod 16), outstanding[g]++, and RR pointer = g+1 mod NUM_REQ.
  - With no issue, div_input_valid=0 and the RR pointer holds.
- Issue-to-divider latency is 1 cycle. End-to-end latency, req accept to rsp_valid, is DIV_LATENCY+2.
- Return: on div_output_valid in RUN, with r = tag[5:4], the next cycle drives:
  - rsp_valid[r]=1, and rsp_quotient/rsp_remainder = divider outputs.
  - outstanding[r]--, expect_seq[r]++.
- err_seq sets (sticky until reset) on a return where any of these hold:
  - r >= NUM_REQ, or
  - tag[3:0] != expect_seq[r], or
  - outstanding[r] == 0.
  - On an error, rsp_valid stays 0 and no counter changes.
- Simultaneous issue and return for the same requester: outstanding is unchanged; both sequence numbers advance.
- Outstanding counters are 5 bits and never wrap; MAX_OUT <= 16 guarantees 4-bit seq uniqueness in flight.
- Reset mid-operation: in-flight results are lost. Requesters must re-issue. The FLUSH window guarantees no stale rsp_valid.
- Arithmetic is pass-through. Quotient sign follows the dividend; the remainder is negated when the dividend is negative.

Decomposition:
- Package divider_sched_pkg holds:
  - TAG_W=6, REQ_ID_W=2, SEQ_W=4.
  - The fsm state enum {FLUSH, RUN}.
  - Tag field position constants.
- One sub-module: rr_arbiter (NUM_REQ-wide round-robin grant from eligible vector and pointer; pure combinational plus pointer register).
- Counters and FSM stay in the top level.

Test Plan:
- Single op, requester 0: dividend 100, divisor 7 accepted at cycle T -> rsp_valid[0] at T+21; quotient 14, remainder 2; tag 0x00.
- Negative dividend, requester 2: dividend -100 (0xFF9C), divisor 7 -> rsp_valid[2]; quotient -14 (0xFFF2), remainder -2 (0xFFFE); tag 0x20.
- Round-robin fairness: all four req_valid held high for 8 cycles -> grants 0,1,2,3,0,1,2,3, and results return in the same order.
- Credit limit: MAX_OUT=2 with requester 1 valid continuously -> two accepts, then req_ready[1]=0 until the first rsp_valid[1], then one more accept.
- Reset mid-flight: 5 ops issued, reset_n pulsed low for 2 cycles -> no rsp_valid for DIV_LATENCY cycles after release; req_ready=0 during FLUSH; err_seq=0.
- Tag fault injection: force div_output_tag=0x05 while expect_seq[0]=0 -> err_seq=1 (sticky), rsp_valid stays 0, outstanding[0] unchanged.
